// File: rtl/dat_crc16_x4.sv
// dat_crc16_x4: four-lane CRC16 (x^16+x^12+x^5+1, init 0, MSB first) for the
// SD DAT bus. It accumulates every valid nibble, shifts the CRC out nibble by
// nibble after a write block, and checks the lane registers against zero
// after a read block plus its CRC.
// Optional build macro: DAT_CRC_CHECK_EN enables the check path (chk_req,
// crc_err, crc_chk_valid). Without it crc_err and crc_chk_valid are tied to 0.
module dat_crc16_x4 (
  input  logic       sd_clk,
  input  logic       rst_L,
  input  logic       clr,
  input  logic [3:0] din,
  input  logic       din_valid,
  input  logic       crc_shift_req,
  input  logic       chk_req,
  output logic [3:0] crc_dout,
  output logic       crc_dout_valid,
  output logic       crc_done,
  output logic [3:0] crc_err,
  output logic       crc_chk_valid,
  output logic       crc_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [3:0][15:0] crc_q;
  logic [3:0][15:0] crc_acc_d;
  logic [3:0][15:0] crc_shl_d;
  logic [3:0]       msb_d;
  logic [3:0]       crc_dout_q;
  logic             crc_dout_valid_q;
  logic             crc_done_q;
  logic             crc_busy_q;

  // One serial CRC16-CCITT step for a single input bit.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Candidate next values per lane: accumulate a data bit, or shift out the MSB.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      crc_acc_d[i] = crc_step(crc_q[i], din[i]);
      crc_shl_d[i] = {crc_q[i][14:0], 1'b0};
      msb_d[i]     = crc_q[i][15];
    end
  end

  // Control FSM with registered shift-out outputs; clr wins over everything.
  always_ff @(posedge sd_clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      crc_q            <= '0;
      crc_dout_q       <= 4'd0;
      crc_dout_valid_q <= 1'b0;
      crc_done_q       <= 1'b0;
      crc_busy_q       <= 1'b0;
    end else begin
      crc_done_q <= 1'b0;
      if (clr) begin
        state_q          <= IDLE;
        cnt_q            <= 4'd0;
        crc_q            <= '0;
        crc_dout_q       <= 4'd0;
        crc_dout_valid_q <= 1'b0;
        crc_busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE, ACCUM: begin
            if (crc_shift_req) begin
              // The first bit (bit 15) leaves on the request edge itself.
              state_q          <= SHIFT;
              cnt_q            <= 4'd15;
              crc_dout_q       <= msb_d;
              crc_q            <= crc_shl_d;
              crc_dout_valid_q <= 1'b1;
              crc_busy_q       <= 1'b1;
            end else if (din_valid) begin
              state_q <= ACCUM;
              crc_q   <= crc_acc_d;
            end
          end
          SHIFT: begin
            if (cnt_q == 4'd0) begin
              // All 16 bits emitted; registers are already zero from the shifts.
              state_q          <= IDLE;
              crc_dout_q       <= 4'd0;
              crc_dout_valid_q <= 1'b0;
              crc_busy_q       <= 1'b0;
            end else begin
              crc_dout_q <= msb_d;
              crc_q      <= crc_shl_d;
              cnt_q      <= cnt_q - 4'd1;
              crc_done_q <= (cnt_q == 4'd1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign crc_dout       = crc_dout_q;
  assign crc_dout_valid = crc_dout_valid_q;
  assign crc_done       = crc_done_q;
  assign crc_busy       = crc_busy_q;

`ifdef DAT_CRC_CHECK_EN
  logic [3:0] crc_err_q;
  logic       crc_chk_valid_q;

  // Zero check of the pre-update registers; ignored while shifting out.
  always_ff @(posedge sd_clk or negedge rst_L) begin
    if (!rst_L) begin
      crc_err_q       <= 4'd0;
      crc_chk_valid_q <= 1'b0;
    end else if (clr) begin
      crc_err_q       <= 4'd0;
      crc_chk_valid_q <= 1'b0;
    end else if (chk_req && (state_q != SHIFT)) begin
      for (int i = 0; i < 4; i++) begin
        crc_err_q[i] <= (crc_q[i] != 16'h0000);
      end
      crc_chk_valid_q <= 1'b1;
    end else begin
      crc_chk_valid_q <= 1'b0;
    end
  end

  assign crc_err       = crc_err_q;
  assign crc_chk_valid = crc_chk_valid_q;
`else
  logic unused_chk_req;
  assign unused_chk_req = chk_req;
  assign crc_err        = 4'b0000;
  assign crc_chk_valid  = 1'b0;
`endif

endmodule

// File: doc/dat_crc16_x4.md
# dat_crc16_x4

Four-lane CRC16 generator/checker for the SD DAT bus, placed next to the DAT physical stage. It sees every data nibble moved across DAT[3:0] and keeps one CRC16 per lane (polynomial x^16+x^12+x^5+1, init 0, no final XOR). On writes it shifts the 16 CRC bits per lane out in nibble order, to fill the CRC slot after a block. On reads it checks the received CRC per lane and reports a pass/fail vector.

## Interface
- No parameters. Lane count is fixed at 4 and CRC width at 16.
- sd_clk  in  1  SD clock. All state changes on the rising edge.
- rst_L  in  1  Asynchronous reset, active low.
- clr  in  1  Synchronous clear of all four CRC registers. Returns the block to IDLE.
- din  in  4  One nibble. Bit i belongs to lane i.
- din_valid  in  1  Accumulate din into the CRC registers this cycle.
- crc_shift_req  in  1  One-cycle pulse that starts 16-cycle CRC output.
- chk_req  in  1  One-cycle pulse that compares the CRC registers against zero.
- crc_dout  out  4  Current CRC bit of each lane during shift-out.
- crc_dout_valid  out  1  High for the 16 shift-out cycles.
- crc_done  out  1  One-cycle pulse on the 16th shift-out cycle.
- crc_err  out  4  Per-lane error result of the last check. Bit i is set when lane i is nonzero.
- crc_chk_valid  out  1  One-cycle pulse when crc_err is updated.
- crc_busy  out  1  High while in SHIFT.

## Operation
- Per-lane update, for each lane i with input bit b = din[i]:
  - fb = crc_i[15] ^ b
  - crc_i = {crc_i[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000)
- States:
  - IDLE: no CRC activity yet. din_valid → ACCUM (that nibble is accumulated). crc_shift_req → SHIFT.
  - ACCUM: each din_valid cycle accumulates. crc_shift_req → SHIFT.
  - SHIFT: 4-bit counter runs 15 down to 0.
    - Each cycle: crc_dout = {crc3[15], crc2[15], crc1[15], crc0[15]}, and every register shifts left with 0 filled in.
    - When the counter reaches 0 → IDLE. All registers are then 0x0000 with no extra clear.
- Input priority, applied in every state: clr > crc_shift_req > din_valid.
  - clr in SHIFT aborts shift-out immediately: crc_dout_valid drops, no crc_done, registers become 0.
  - din_valid and crc_shift_req are ignored in SHIFT.
- Check (read path):
  - The caller feeds the data nibbles followed by the 16 received CRC nibbles through din_valid.
  - chk_req then sets crc_err[i] = (crc_i != 0).
  - A correct lane leaves exactly zero, because a CCITT CRC with init 0 over data+CRC is 0.
  - chk_req has no effect on the registers or the state, and is ignored in SHIFT.
  - chk_req together with din_valid in the same cycle checks the pre-update values.
- Bit order: MSB first on both paths.

## Timing
- Reset values:
  - CRC registers = 0, state = IDLE, counter = 0.
  - crc_dout = 0, crc_dout_valid = 0, crc_done = 0, crc_err = 0, crc_chk_valid = 0, crc_busy = 0.
- All outputs are registered.
- din_valid at edge N: the updated CRC is visible internally after edge N. A shift request at edge N+1 sees it.
- crc_shift_req at edge N:
  - crc_dout_valid and crc_busy are high during cycles N+1 through N+16.
  - crc_dout carries bit 15 in cycle N+1 and bit 0 in cycle N+16.
  - crc_done is high in cycle N+16 only.
  - A back-to-back crc_shift_req at N+16 is ignored, because the block is still in SHIFT.
- chk_req at edge N: crc_err and crc_chk_valid update after edge N. crc_chk_valid is high for one cycle. crc_err holds until the next check, clr, or reset.
- clr at edge N: registers are 0 and state is IDLE after N. crc_err clears to 0.
- Asynchronous reset mid-shift returns every output to its reset value immediately.

## Configuration
- DAT_CRC_CHECK_EN defined: chk_req, crc_err and crc_chk_valid are implemented as described.
- Not defined: check logic is removed, chk_req is ignored, crc_err is tied to 4'b0000 and crc_chk_valid is tied to 0. Generation is unchanged.

## Test plan
- Reset during SHIFT cycle 5 → all outputs 0 immediately. A later shift with no data emits sixteen 0 nibbles.
- clr, one din_valid with din=4'b0001, then crc_shift_req → lane0 = 0x1021, lanes 1-3 = 0.
  - crc_dout over 16 cycles = 0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,1.
  - crc_done in the 16th cycle.
- din=4'b1111 once, shift out, feed the 16 emitted nibbles back with din_valid, then chk_req → crc_err=4'b0000, crc_chk_valid pulse.
- Same as above with bit 2 of the 5th CRC nibble flipped → crc_err=4'b0100.
- clr asserted in SHIFT cycle 8 → crc_dout_valid low next cycle, no crc_done, registers 0. din_valid asserted during SHIFT is ignored: CRC unchanged after SHIFT.
- Built without DAT_CRC_CHECK_EN: chk_req after corrupted data → crc_err=0, crc_chk_valid never asserts.
